// File: rtl/alu_pkg.sv
// alu_pkg: opcode constants, flag bit positions and the buffered-entry type for the ALU result stage
package alu_pkg;
    localparam logic [3:0] OP_AND = 4'b0000;
    localparam logic [3:0] OP_OR  = 4'b0001;
    localparam logic [3:0] OP_ADD = 4'b0010;
    localparam logic [3:0] OP_SUB = 4'b0110;
    localparam logic [3:0] OP_SLT = 4'b0111;
    localparam logic [3:0] OP_NOR = 4'b1100;
    localparam int FLAG_N = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;
    typedef struct packed {
        logic [31:0] result;
        logic [3:0]  flags;
    } entry_t;
    typedef enum logic [1:0] {EMPTY, ONE, FULL} occ_e;
endpackage

// File: rtl/alu_result_stage_if.sv
// alu_result_stage_if: upstream result handshake and downstream entry handshake
interface alu_result_stage_if;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  in_opcode;
    logic [31:0] in_result;
    logic        in_cout;
    logic        in_overflow;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_result;
    logic [3:0]  out_flags;
    modport slave (
        input  in_valid, in_opcode, in_result, in_cout, in_overflow, out_ready,
        output in_ready, out_valid, out_result, out_flags
    );
    modport master (
        output in_valid, in_opcode, in_result, in_cout, in_overflow, out_ready,
        input  in_ready, out_valid, out_result, out_flags
    );
endinterface

// File: rtl/alu_flag_gen.sv
// alu_flag_gen: combinational {N,Z,C,V}; carry and overflow only meaningful for add/sub
module alu_flag_gen
    import alu_pkg::*;
(
    input  logic [3:0]  opcode,
    input  logic [31:0] result,
    input  logic        cout,
    input  logic        overflow,
    output logic [3:0]  flags
);
    logic arith;
    always_comb begin
        arith = opcode[1:0] == 2'b10;
        flags = '0;
        flags[FLAG_N] = result[31];
        flags[FLAG_Z] = result == '0;
        flags[FLAG_C] = arith & cout;
        flags[FLAG_V] = arith & overflow;
    end
endmodule

// File: rtl/alu_result_stage.sv
// alu_result_stage: two-entry skid buffer for ALU results with flag capture, sticky overflow and op counter
module alu_result_stage
    import alu_pkg::*;
#(
    parameter int DEPTH = 2,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    alu_result_stage_if.slave bus,
    input  logic             clr_sticky,
    output logic             sticky_ovf,
    output logic [CNT_W-1:0] op_count
);
    occ_e             state_q, state_d;
    entry_t           mem_q [DEPTH];
    entry_t           mem_d [DEPTH];
    logic             wr_q, wr_d, rd_q, rd_d;
    logic             sticky_q, sticky_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [3:0]       flags;
    logic             push, pop;

    alu_flag_gen u_flag_gen (
        .opcode   (bus.in_opcode),
        .result   (bus.in_result),
        .cout     (bus.in_cout),
        .overflow (bus.in_overflow),
        .flags    (flags)
    );

    assign bus.in_ready   = rst_n && state_q != FULL;
    assign bus.out_valid  = state_q != EMPTY;
    assign bus.out_result = mem_q[rd_q].result;
    assign bus.out_flags  = mem_q[rd_q].flags;
    assign sticky_ovf     = sticky_q;
    assign op_count       = cnt_q;
    assign push           = bus.in_valid && bus.in_ready;
    assign pop            = bus.out_valid && bus.out_ready;

    always_comb begin
        state_d = (push && !pop) ? (state_q == EMPTY ? ONE : FULL) :
                  (pop && !push) ? (state_q == FULL ? ONE : EMPTY) : state_q;
        wr_d = wr_q ^ push;
        rd_d = rd_q ^ pop;
        mem_d = mem_q;
        if (push) mem_d[wr_q] = '{result: bus.in_result, flags: flags};
        sticky_d = (sticky_q && !clr_sticky) || (push && flags[FLAG_V]);
        cnt_d = cnt_q + CNT_W'(pop);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= EMPTY;
            wr_q     <= 1'b0;
            rd_q     <= 1'b0;
            sticky_q <= 1'b0;
            cnt_q    <= '0;
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else begin
            state_q  <= state_d;
            wr_q     <= wr_d;
            rd_q     <= rd_d;
            sticky_q <= sticky_d;
            cnt_q    <= cnt_d;
            mem_q    <= mem_d;
        end
    end
endmodule

// File: doc/alu_result_stage.md
ALU_RESULT_STAGE -- requirements
Module: alu_result_stage

Interface
REQ-001 Parameter DEPTH, default 2: number of buffered result entries; legal values 2 only (fixed skid depth).
REQ-002 Parameter CNT_W, default 16: width of the completed-operation counter.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst_n  input  1  reset, synchronous, active-low.
REQ-005 in_valid  input  1  upstream ALU result is presented this cycle.
REQ-006 in_ready  output  1  stage can accept a result this cycle.
REQ-007 in_opcode  input  4  opcode that produced the result: {ainv, binv, op[1:0]}.
REQ-008 in_result  input  32  ALU result word.
REQ-009 in_cout  input  1  ALU carry-out of bit 31.
REQ-010 in_overflow  input  1  ALU signed overflow.
REQ-011 out_valid  output  1  buffered entry is presented downstream.
REQ-012 out_ready  input  1  downstream accepts the presented entry.
REQ-013 out_result  output  32  result word of the head entry.
REQ-014 out_flags  output  4  {N, Z, C, V} of the head entry.
REQ-015 sticky_ovf  output  1  an overflowing arithmetic result has been accepted since the last clear.
REQ-016 clr_sticky  input  1  clear sticky_ovf.
REQ-017 op_count  output  CNT_W  number of output handshakes completed, modulo 2^CNT_W.

Function
REQ-018 Input handshake: entry accepted on a rising edge where in_valid and in_ready are both 1; output handshake: out_valid and out_ready both 1.
REQ-019 in_ready SHALL equal 1 exactly when fewer than 2 entries are held, derived from registered occupancy only (no combinational path from out_ready).
REQ-020 Latency: an entry accepted into an empty stage SHALL be presented with out_valid=1 on the next cycle; no combinational input-to-output path.
REQ-021 Entries SHALL leave in acceptance order; out_result/out_flags SHALL stay stable while out_valid=1 and out_ready=0.
REQ-022 Simultaneous push and pop SHALL keep occupancy unchanged; with 1 entry held both occur in the same cycle without bubble.
REQ-023 Flags computed at acceptance: N = in_result[31]; Z = (in_result == 0).
REQ-024 C = in_cout and V = in_overflow only when in_opcode[1:0] = 2'b10 (add/sub); otherwise C = 0, V = 0.
REQ-025 Occupancy 0: out_valid=0, out_result/out_flags hold last values (don't-care for checking); occupancy 2: in_ready=0, in_valid ignored.
REQ-026 Occupancy state machine states EMPTY, ONE, FULL: EMPTY->ONE on push; ONE->FULL on push without pop; ONE->EMPTY on pop without push; FULL->ONE on pop; all other cases hold.
REQ-027 sticky_ovf SHALL set on any accepted entry with V=1; clr_sticky clears it; same-cycle set and clear SHALL leave it set.
REQ-028 op_count SHALL increment by 1 per output handshake and wrap from 2^CNT_W-1 to 0.

Reset
REQ-029 On a rising edge with rst_n=0: occupancy EMPTY, out_valid=0, in_ready=0 during that cycle then 1 after release, out_result=0, out_flags=0, sticky_ovf=0, op_count=0.
REQ-030 Reset mid-operation SHALL discard all held entries; no handshake completed in a reset cycle SHALL count.

Structure
REQ-031 Shared package alu_pkg SHALL hold opcode constants (AND=4'b0000, OR=4'b0001, ADD=4'b0010, SUB=4'b0110, SLT=4'b0111, NOR=4'b1100), flag bit indices N=3, Z=2, C=1, V=0, and the buffered-entry struct {result[31:0], flags[3:0]}.
REQ-032 One sub-module alu_flag_gen SHALL compute {N,Z,C,V} combinationally from opcode, result, cout, overflow.

Verification
REQ-033 Reset then ADD result 0x00000000, cout=1, overflow=0 pushed -> next cycle out_valid=1, out_result=0, out_flags=4'b0110.
REQ-034 SUB 0x7FFFFFFF - 0xFFFFFFFF: result 0x80000000, overflow=1 -> out_flags=4'b1001, sticky_ovf=1; clr_sticky with concurrent overflowing push -> sticky_ovf stays 1.
REQ-035 AND result 0x80000000 with cout=1, overflow=1 -> out_flags=4'b1000, sticky_ovf unchanged.
REQ-036 out_ready=0, push 3 back-to-back -> in_ready=0 after second accept, third held upstream; release out_ready -> three results in order, no drop or duplicate.
REQ-037 Continuous in_valid and out_ready=1 for 70000 cycles -> one result per cycle after first, op_count wraps past 0xFFFF to equal 70000 mod 65536 minus initial latency.
REQ-038 rst_n low for one cycle while FULL -> out_valid=0 next cycle, op_count=0, earlier entries never appear.
